rr_mux_arb: RTL
===============

Name: rr_mux_arb

Overview:
- Parametrised successor to the team's 2:1 combinational selector.
- Selects one of N input channels, each W bits wide, with per-channel valid/ready handshake.
- Arbitration is fixed-priority or round-robin, chosen at run time; the winner is registered onto a single output stage with valid/ready backpressure.
- Sits between multiple producers and one shared consumer in the datapath.

Parameters:
- N, 4, number of input channels; legal range 2..16.
- W, 8, data width per channel.
- CW, derived as clog2(N) (localparam, not overridable), width of the channel-index output.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- in_valid  in  N  bit i set = channel i presents data.
- in_data  in  N*W  channel i data at bits [i*W +: W].
- in_ready  out  N  bit i set = channel i transfers this cycle if valid.
- out_valid  out  1  output register holds a valid word.
- out_data  out  W  registered data of the granted channel.
- out_ch  out  CW  index of the channel that produced out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset, with rst high at a rising edge:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=N-1, so channel 0 has top priority first.
  - Reset overrides everything, including a word held under backpressure, which is dropped.
  - in_ready is forced to all-zero while rst is high.
- Load enable: load = !out_valid | out_ready. This is combinational.
- Grant selection (combinational):
  - mode=0: g = lowest index i with in_valid[i]=1.
  - mode=1: g = first i with in_valid[i]=1, searching ptr+1, ptr+2, ... with wrap modulo N.
- in_ready:
  - in_ready = onehot(g) when load=1 and at least one in_valid bit is set; otherwise in_ready=0.
  - At most one bit is ever set.
  - in_ready may depend combinationally on in_valid and out_ready. This path is allowed.
- Transfer, on a clock edge with load=1 and any in_valid set:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1, ptr <= g.
  - ptr updates in both modes; it only affects arbitration while mode=1.
- Load=1 with no in_valid set: out_valid <= 0. out_data and out_ch hold their old values (don't-care).
- Stall, out_valid=1 and out_ready=0:
  - out_valid, out_data, out_ch and ptr hold.
  - in_ready=0.
- Latency and throughput:
  - Exactly 1 cycle from input handshake to out_valid.
  - With out_ready held high, one word per cycle, no bubbles.
- Simultaneous events: out_ready=1 with a new grant in the same cycle means the old word leaves and the new word loads on the same edge.
- Mode changes: mode is sampled every cycle and takes effect on the next grant. No state is cleared on a mode change.
- Wrap: with ptr=N-1 in mode 1, the search starts at channel 0.
- Input data is never modified. No arithmetic is performed on the data path.

Test Plan:
1. Reset, then idle: assert rst for 2 cycles with all in_valid=1.
   -> in_ready=0, out_valid=0, out_data=0, out_ch=0 throughout reset.
   -> First grant after release goes to channel 0.
2. Fixed priority: mode=0, N=4, in_valid=4'b1010, data ch1=0x11, ch3=0x33, out_ready=1.
   -> Every cycle grants ch1; out_data=0x11, out_ch=1 from the second cycle on.
   -> ch3 is never granted.
3. Round-robin: mode=1, in_valid=4'b1111, data ch i = 0xA0+i, out_ready=1.
   -> out_ch sequence 0,1,2,3,0,... one per cycle.
   -> out_data follows as 0xA0,0xA1,0xA2,0xA3,0xA0,...
4. Backpressure: mode=1, hold out_ready=0 for 3 cycles after the first grant (ch0).
   -> out_data=0xA0 and out_ch=0 stable; in_ready=0 during the stall.
   -> On the cycle out_ready returns to 1, in_ready=4'b0010 and ch1 loads on the same edge.
5. Sparse round-robin with wrap: ptr=2 (last grant ch2), in_valid=4'b0011.
   -> Grant goes to ch0, then ch1, then ch0.
   -> Pointer wraps correctly past ch3.
6. Reset mid-stall: out_valid=1, out_ready=0, then pulse rst for 1 cycle.
   -> out_valid=0 on the next cycle and the held word is lost.
   -> After release in mode 1, the first grant is the lowest valid index.

Source files
------------

// File: rtl/rr_mux_arb.sv
// N-channel selector with run-time fixed-priority / round-robin arbitration.
// The winning word is registered into a single valid/ready output stage.
module rr_mux_arb #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_ch,
  input  logic                 out_ready
);

  localparam int CW = $clog2(N);

  logic [CW-1:0] ptr_r;
  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic [CW-1:0] out_ch_r;

  logic          load_s;
  logic          any_s;
  logic [CW-1:0] grant_s;
  logic [N-1:0]  in_ready_s;

  // Lowest-index requester wins; the last match in a descending scan is the lowest.
  function automatic logic [CW-1:0] pick_fixed(input logic [N-1:0] v);
    logic [CW-1:0] g;
    logic [CW-1:0] idx;
    g = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = CW'(i);
      if (v[idx]) begin
        g = idx;
      end
    end
    return g;
  endfunction

  // Nearest requester after p (wrapping), scanned far-to-near so the closest one sticks.
  function automatic logic [CW-1:0] pick_rr(input logic [N-1:0] v, input logic [CW-1:0] p);
    logic [CW-1:0] g;
    logic [CW-1:0] idx;
    g = '0;
    for (int k = N; k >= 1; k--) begin
      idx = CW'((int'(p) + k) % N);
      if (v[idx]) begin
        g = idx;
      end
    end
    return g;
  endfunction

  // Output stage can accept a new word when empty or draining this cycle.
  always_comb begin
    load_s = !out_valid_r || out_ready;
    any_s  = |in_valid;
  end

  // Grant selection for the current arbitration mode.
  always_comb begin
    grant_s = '0;
    if (mode) begin
      grant_s = pick_rr(in_valid, ptr_r);
    end else begin
      grant_s = pick_fixed(in_valid);
    end
  end

  // One-hot ready toward the granted producer; suppressed in reset.
  always_comb begin
    in_ready_s = '0;
    if (!rst && load_s && any_s) begin
      in_ready_s = {{(N-1){1'b0}}, 1'b1} << grant_s;
    end else begin
      in_ready_s = '0;
    end
  end

  // Output register and round-robin pointer; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      ptr_r       <= CW'(N - 1);
    end else if (load_s) begin
      if (any_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= in_data[grant_s*W +: W];
        out_ch_r    <= grant_s;
        ptr_r       <= grant_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule
